// File: rtl/nor_flash_ctrl.sv
// Host-side controller for an x8 StrataFlash-style parallel NOR device.
// Sequences Read Array and Program operations as timed write/read bus cycles with status polling.
module nor_flash_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int T_WP     = 4,
  parameter int T_RD     = 6,
  parameter int T_GAP    = 2,
  parameter int T_RPH    = 8,
  parameter int POLL_MAX = 65535
) (
  input  logic              CLK_50MHZ,
  input  logic              RST,
  input  logic              TRG_READ,
  input  logic              TRG_WRITE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [7:0]        DATA_IN,
  output logic [7:0]        DATA_OUT,
  output logic [7:0]        STATUS,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic              FLASH_RDY,
  output logic [ADDR_W-1:0] NF_A,
  inout  wire  [7:0]        NF_D,
  output logic              NF_CE,
  output logic              NF_OE,
  output logic              NF_WE,
  output logic              NF_BYTE,
  output logic              NF_WP,
  output logic              NF_RP,
  input  logic              NF_STS
);

  typedef enum logic [3:0] {
    ST_RPH, ST_IDLE, ST_RD_FF, ST_RD_ARR, ST_PG_40, ST_PG_DAT,
    ST_PG_POLL, ST_PG_50, ST_PG_FF, ST_DONE
  } state_t;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] WR_HOLD  = CNT_W'(T_WP + 1);
  localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(T_WP + 1 + T_GAP);
  localparam logic [CNT_W-1:0] RD_SMP   = CNT_W'(T_RD - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(T_RD + T_GAP);
  localparam logic [CNT_W-1:0] RPH_LAST = CNT_W'(T_RPH - 1);
  localparam logic [15:0]      POLL_LIM = 16'(POLL_MAX);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [7:0]         data_out_q, data_out_d;
  logic [7:0]         status_q, status_d;
  logic               err_q, err_d;
  logic [15:0]        poll_q, poll_d;
  logic               rp_q;
  logic               sts_meta_q, sts_sync_q;

  logic               is_wr, is_rd, bus_last, drive_d;
  logic [7:0]         wr_byte;

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      state_q    <= ST_RPH;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_out_q <= '0;
      status_q   <= '0;
      err_q      <= 1'b0;
      poll_q     <= '0;
      rp_q       <= 1'b0;
      sts_meta_q <= 1'b0;
      sts_sync_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      status_q   <= status_d;
      err_q      <= err_d;
      poll_q     <= poll_d;
      rp_q       <= 1'b1;
      sts_meta_q <= NF_STS;
      sts_sync_q <= sts_meta_q;
    end
  end

  always_comb begin
    is_wr = (state_q == ST_RD_FF) || (state_q == ST_PG_40) || (state_q == ST_PG_DAT) ||
            (state_q == ST_PG_50) || (state_q == ST_PG_FF);
    is_rd = (state_q == ST_RD_ARR) || (state_q == ST_PG_POLL);
    bus_last = is_wr ? (cnt_q == WR_LAST) : (cnt_q == RD_LAST);
    case (state_q)
      ST_PG_40:  wr_byte = 8'h40;
      ST_PG_DAT: wr_byte = wdata_q;
      ST_PG_50:  wr_byte = 8'h50;
      default:   wr_byte = 8'hFF;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    status_d   = status_q;
    err_d      = err_q;
    poll_d     = poll_q;
    case (state_q)
      ST_RPH: if (cnt_q == RPH_LAST) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (TRG_WRITE) begin
          addr_d  = ADDR;
          wdata_d = DATA_IN;
          err_d   = 1'b0;
          poll_d  = '0;
          state_d = ST_PG_40;
        end else if (TRG_READ) begin
          addr_d  = ADDR;
          state_d = ST_RD_FF;
        end
      end
      ST_RD_FF: if (bus_last) begin
        state_d = ST_RD_ARR;
        cnt_d   = '0;
      end
      ST_RD_ARR: begin
        if (cnt_q == RD_SMP) data_out_d = NF_D;
        if (bus_last) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end
      ST_PG_40: if (bus_last) begin
        state_d = ST_PG_DAT;
        cnt_d   = '0;
      end
      ST_PG_DAT: if (bus_last) begin
        state_d = ST_PG_POLL;
        cnt_d   = '0;
      end
      ST_PG_POLL: begin
        if (cnt_q == RD_SMP) begin
          status_d = NF_D;
          if (poll_q != 16'hFFFF) poll_d = poll_q + 16'd1;
        end
        if (bus_last) begin
          cnt_d = '0;
          // Exit on ready, or on the poll budget; a still-busy device counts as a failure.
          if (status_q[7] || (poll_q >= POLL_LIM)) begin
            err_d   = status_q[1] | status_q[3] | status_q[4] | ~status_q[7];
            state_d = err_d ? ST_PG_50 : ST_PG_FF;
          end
        end
      end
      ST_PG_50: if (bus_last) begin
        state_d = ST_PG_FF;
        cnt_d   = '0;
      end
      ST_PG_FF: if (bus_last) begin
        state_d = ST_DONE;
        cnt_d   = '0;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_RPH;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobes are decoded from registered state/count; data is driven only while CE is low in a write.
  assign drive_d   = is_wr && (cnt_q <= WR_HOLD);
  assign NF_CE     = ~(drive_d || (is_rd && (cnt_q <= RD_SMP)));
  assign NF_OE     = ~(is_rd && (cnt_q <= RD_SMP));
  assign NF_WE     = ~(is_wr && (cnt_q >= CNT_W'(1)) && (cnt_q <= CNT_W'(T_WP)));
  assign NF_D      = drive_d ? wr_byte : 8'hzz;
  assign NF_A      = addr_q;
  assign NF_BYTE   = 1'b0;
  assign NF_WP     = 1'b1;
  assign NF_RP     = rp_q;
  assign DATA_OUT  = data_out_q;
  assign STATUS    = status_q;
  assign ERR       = err_q;
  assign BUSY      = (state_q != ST_IDLE);
  assign DONE      = (state_q == ST_DONE);
  assign FLASH_RDY = sts_sync_q;

endmodule

// File: tb/tb_nor_flash_ctrl.sv
// Bench for nor_flash_ctrl: behavioural flash responder plus an operation scoreboard.
// Each operation pushes its expected outcome; the entry is popped and compared on DONE.
module tb_nor_flash_ctrl;
  localparam int POLL_MAX = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trg_read = 1'b0, trg_write = 1'b0;
  logic [7:0] addr = '0, data_in = '0;
  logic [7:0] data_out, status;
  logic       busy, done, err, flash_rdy;
  logic [7:0] nf_a;
  wire  [7:0] nf_d;
  logic       nf_ce, nf_oe, nf_we, nf_byte, nf_wp, nf_rp;
  logic       nf_sts = 1'b1;

  always #10 clk = ~clk;

  nor_flash_ctrl #(.POLL_MAX(POLL_MAX)) dut (
    .CLK_50MHZ(clk), .RST(rst), .TRG_READ(trg_read), .TRG_WRITE(trg_write),
    .ADDR(addr), .DATA_IN(data_in), .DATA_OUT(data_out), .STATUS(status),
    .BUSY(busy), .DONE(done), .ERR(err), .FLASH_RDY(flash_rdy),
    .NF_A(nf_a), .NF_D(nf_d), .NF_CE(nf_ce), .NF_OE(nf_oe), .NF_WE(nf_we),
    .NF_BYTE(nf_byte), .NF_WP(nf_wp), .NF_RP(nf_rp), .NF_STS(nf_sts)
  );

  function automatic logic [7:0] init_byte(input int a);
    logic [7:0] v;
    v = 8'(a) ^ 8'h3C;
    if (a == 8'h12) v = 8'hA5;
    return v;
  endfunction

  // ---------------- flash responder ----------------
  logic [7:0] mem [256];
  logic       mem_init = 1'b0;
  logic       mode_status = 1'b0, pend = 1'b0;
  int         busy_left = 0;
  logic [7:0] sr_err = '0;
  logic       prev_we = 1'b1, prev_oe = 1'b1;
  int         cfg_busy = 0;
  logic [7:0] cfg_err = '0;
  logic       cfg_stuck = 1'b0;
  logic [7:0] cmd_q[$];
  int         stat_cnt = 0;
  int         viol = 0;
  int         cyc = 0;
  logic [7:0] rd_val;

  always_comb begin
    rd_val = 8'h00;
    if (!mode_status) rd_val = mem[nf_a];
    else if (busy_left == 0 && !cfg_stuck) rd_val = 8'h80 | sr_err;
  end
  assign nf_d = (!nf_ce && !nf_oe) ? rd_val : 8'hzz;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_we <= nf_we;
    prev_oe <= nf_oe;
    if ((!nf_oe && !nf_we) || (!nf_ce && !nf_oe && $isunknown(nf_d))) viol <= viol + 1;
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
      mem_init <= 1'b1;
    end
    if (!nf_rp) begin
      mode_status <= 1'b0;
      pend        <= 1'b0;
      busy_left   <= 0;
    end else begin
      if (!prev_we && nf_we && !nf_ce) begin
        cmd_q.push_back(nf_d);
        if (pend) begin
          mem[nf_a]   <= nf_d;
          pend        <= 1'b0;
          mode_status <= 1'b1;
          busy_left   <= cfg_busy;
          sr_err      <= cfg_err;
        end else begin
          case (nf_d)
            8'hFF:   mode_status <= 1'b0;
            8'h40:   pend <= 1'b1;
            8'h50:   sr_err <= '0;
            default: ;
          endcase
        end
      end
      if (!prev_oe && nf_oe && mode_status) begin
        stat_cnt <= stat_cnt + 1;
        if (busy_left != 0) busy_left <= busy_left - 1;
      end
    end
  end

  // ---------------- checking and scoreboard ----------------
  typedef struct {
    int         kind;
    int         acc;
    logic [7:0] exp_data;
    logic [7:0] exp_status;
    logic       exp_err;
    logic [31:0] exp_cmds;
    int         exp_ncmd;
    int         exp_nstat;
    int         cmd_base;
    int         stat_base;
  } sb_item_t;

  sb_item_t   sb_q[$];
  int         n_cmp = 0, n_bad = 0;
  logic [7:0] exp_mem [256];
  logic [7:0] exp_data_st = '0, exp_status_st = '0;
  logic       exp_err_st = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (busy) check_val("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic count_rph();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("rph_clocks", 32'(n), 32'd8);
  endtask

  // kind: 0 read, 1 program, 2 both triggers together
  task automatic do_op(input int kind, input logic [7:0] a, input logic [7:0] d,
                       input int nbusy, input logic [7:0] errb, input logic stuck,
                       input logic inject);
    sb_item_t    it, got;
    int          n;
    logic [31:0] w;
    logic        tmo;
    wait_idle();
    cfg_busy  = nbusy;
    cfg_err   = errb;
    cfg_stuck = stuck;
    it.kind      = kind;
    it.cmd_base  = cmd_q.size();
    it.stat_base = stat_cnt;
    if (kind == 0) begin
      exp_data_st  = exp_mem[a];
      it.exp_cmds  = 32'h0000_00FF;
      it.exp_ncmd  = 1;
      it.exp_nstat = 0;
    end else begin
      tmo           = stuck || (nbusy + 1 > POLL_MAX);
      exp_status_st = tmo ? 8'h00 : (8'h80 | errb);
      exp_err_st    = tmo || ((exp_status_st & 8'h1A) != 8'h00);
      exp_mem[a]    = d;
      it.exp_nstat  = tmo ? POLL_MAX : nbusy + 1;
      if (exp_err_st) begin
        it.exp_cmds = {8'h40, d, 8'h50, 8'hFF};
        it.exp_ncmd = 4;
      end else begin
        it.exp_cmds = {8'h00, 8'h40, d, 8'hFF};
        it.exp_ncmd = 3;
      end
    end
    it.exp_data   = exp_data_st;
    it.exp_status = exp_status_st;
    it.exp_err    = exp_err_st;
    it.acc        = cyc;
    sb_q.push_back(it);
    addr      = a;
    data_in   = d;
    trg_read  = (kind != 1);
    trg_write = (kind != 0);
    @(negedge clk);
    trg_read  = 1'b0;
    trg_write = 1'b0;
    if (inject) begin
      repeat (5) @(negedge clk);
      addr     = 8'h12;
      trg_read = 1'b1;
      @(negedge clk);
      trg_read = 1'b0;
    end
    n = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    got = sb_q.pop_front();
    if (!done) begin
      check_val("done_timeout", 32'd0, 32'd1);
      return;
    end
    w = '0;
    for (int i = got.cmd_base; i < cmd_q.size(); i++) w = (w << 8) | 32'(cmd_q[i]);
    $display("op kind=%0d addr=%h data=%h: dout=%h st=%h err=%b cmds=%h nstat=%0d lat=%0d",
             kind, a, d, data_out, status, err, w, stat_cnt - got.stat_base, cyc - got.acc);
    check_val("data_out", 32'(data_out), 32'(got.exp_data));
    check_val("status", 32'(status), 32'(got.exp_status));
    check_val("err", 32'(err), 32'(got.exp_err));
    check_val("cmd_seq", w, got.exp_cmds);
    check_val("cmd_count", 32'(cmd_q.size() - got.cmd_base), 32'(got.exp_ncmd));
    check_val("status_reads", 32'(stat_cnt - got.stat_base), 32'(got.exp_nstat));
    check_val("busy_at_done", 32'(busy), 32'd1);
    if (got.kind == 0) check_val("read_latency", 32'(cyc - got.acc), 32'd18);
    @(negedge clk);
    check_val("busy_done_after", {30'd0, busy, done}, 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_strobes"}, {29'd0, nf_ce, nf_oe, nf_we}, 32'h7);
    check_val({tag, "_rp"}, 32'(nf_rp), 32'd0);
    check_val({tag, "_nfd"}, {24'd0, nf_d}, 32'h0000_00zz);
    check_val({tag, "_busy_done_err"}, {29'd0, busy, done, err}, 32'h4);
    check_val({tag, "_dout_stat"}, {16'd0, data_out, status}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) exp_mem[i] = init_byte(i);
    #35;
    check_reset_state("por");
    check_val("por_flash_rdy", 32'(flash_rdy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    count_rph();
    check_val("flash_rdy_sync", 32'(flash_rdy), 32'd1);

    do_op(0, 8'h12, 8'h00, 0, 8'h00, 1'b0, 1'b0);  // read preloaded byte
    do_op(1, 8'h34, 8'h55, 3, 8'h00, 1'b0, 1'b0);  // ready on the last allowed poll
    do_op(0, 8'h34, 8'h00, 0, 8'h00, 1'b0, 1'b0);
    do_op(1, 8'h20, 8'h66, 1, 8'h10, 1'b0, 1'b0);  // status 0x90 -> error path
    do_op(0, 8'h20, 8'h00, 0, 8'h00, 1'b0, 1'b0);  // read keeps ERR
    do_op(1, 8'h21, 8'h01, 0, 8'h00, 1'b0, 1'b0);  // next write clears ERR
    do_op(1, 8'h22, 8'h02, 0, 8'h00, 1'b1, 1'b0);  // SR7 stuck -> timeout
    do_op(2, 8'h56, 8'h77, 2, 8'h00, 1'b0, 1'b1);  // both triggers, read injected while busy
    do_op(0, 8'h56, 8'h00, 0, 8'h00, 1'b0, 1'b0);

    // abort a program in flight
    wait_idle();
    cfg_busy  = 20;
    addr      = 8'h77;
    data_in   = 8'h11;
    trg_write = 1'b1;
    @(negedge clk);
    trg_write = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_state("mid_rst");
    exp_data_st   = '0;
    exp_status_st = '0;
    exp_err_st    = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    count_rph();
    do_op(0, 8'h12, 8'h00, 0, 8'h00, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check_val("bus_violations", 32'(viol), 32'd0);
    check_val("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
